// File: rtl/shift_register_pkg.sv
// Shared SPI datapath definitions: shift register operation encodings and
// the default datapath width used by the SPI controller.
package shift_register_pkg;

  localparam int SR_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_SHR  = 2'b01,
    SR_SHL  = 2'b10,
    SR_LOAD = 2'b11
  } sr_mode_e;

endpackage : shift_register_pkg

// File: rtl/shift_register.sv
// Universal shift register for the SPI datapath: hold, shift right
// (LSB-first), shift left (MSB-first) and parallel load. The parallel view is
// gated by an active-low enable; the serial view always shows the bit that the
// next shift in the current direction would push out.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int WIDTH = SR_DEFAULT_WIDTH  // must be >= 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_mode,
  input  logic             i_output_enable_n,
  input  logic [WIDTH-1:0] i_parallel,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_parallel,
  output logic             o_serial
);

  logic [WIDTH-1:0] data_q;

  // Register update: reset discards any in-flight word; one operation per edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
    end else begin
      case (i_mode)
        SR_HOLD: data_q <= data_q;
        SR_SHR:  data_q <= {i_serial, data_q[WIDTH-1:1]};
        SR_SHL:  data_q <= {data_q[WIDTH-2:0], i_serial};
        SR_LOAD: data_q <= i_parallel;
        default: data_q <= data_q;
      endcase
    end
  end

  // Parallel view is gated; the register itself is unaffected by the enable.
  assign o_parallel = i_output_enable_n ? '0 : data_q;

  // Serial view follows the shift direction; hold and load present bit 0.
  assign o_serial = (i_mode == SR_SHL) ? data_q[WIDTH-1] : data_q[0];

endmodule : shift_register

// File: tb/tb_shift_register.sv
// Directed bench for shift_register (WIDTH = 8).
module tb_shift_register;
  import shift_register_pkg::*;

  logic       i_clk;
  logic       i_rst;
  logic [1:0] i_mode;
  logic       i_output_enable_n;
  logic [7:0] i_parallel;
  logic       i_serial;
  logic [7:0] o_parallel;
  logic       o_serial;

  int checks   = 0;
  int failures = 0;

  shift_register #(.WIDTH(8)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_mode            (i_mode),
    .i_output_enable_n (i_output_enable_n),
    .i_parallel        (i_parallel),
    .i_serial          (i_serial),
    .o_parallel        (o_parallel),
    .o_serial          (o_serial)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 ns past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic shr_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      i_mode   = SR_SHR;
      i_serial = w[i];
      tick();
    end
    i_mode = SR_HOLD;
    #1;
  endtask

  task automatic shl_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      i_mode   = SR_SHL;
      i_serial = w[i];
      tick();
    end
    i_mode = SR_HOLD;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    logic [7:0] seq;

    i_rst             = 1'b0;
    i_mode            = SR_HOLD;
    i_output_enable_n = 1'b1;
    i_parallel        = 8'h00;
    i_serial          = 1'b0;
    #1;

    // 1. reset
    i_rst = 1'b1;
    repeat (16) tick();
    i_output_enable_n = 1'b0;
    #1;
    check("reset_par_in_reset", o_parallel, 8'h00);
    i_output_enable_n = 1'b1;
    i_rst = 1'b0;
    tick();
    check("reset_par", o_parallel, 8'h00);
    check("reset_ser", {7'b0, o_serial}, 8'h00);

    // 2. right shift
    i_output_enable_n = 1'b1;
    shr_word(8'hA5);
    check("shr_gated", o_parallel, 8'h00);
    i_output_enable_n = 1'b0;
    #1;
    check("shr_a5", o_parallel, 8'hA5);
    for (int n = 0; n < 100; n++) begin
      w = 8'($urandom_range(0, 255));
      i_output_enable_n = 1'b1;
      shr_word(w);
      i_output_enable_n = 1'b0;
      #1;
      check("shr_rand", o_parallel, w);
    end

    // 3. left shift
    i_output_enable_n = 1'b1;
    shl_word(8'h3C);
    i_output_enable_n = 1'b0;
    #1;
    check("shl_3c", o_parallel, 8'h3C);
    for (int n = 0; n < 100; n++) begin
      w = 8'($urandom_range(0, 255));
      shl_word(w);
      check("shl_rand", o_parallel, w);
    end

    // 4. parallel load, hold, gating
    i_parallel = 8'hC3;
    i_serial   = 1'b0;
    i_mode     = SR_LOAD;
    #1;
    check("ser_load_mode", {7'b0, o_serial}, {7'b0, w[0]});
    tick();
    i_mode = SR_HOLD;
    i_output_enable_n = 1'b0;
    #1;
    check("load_c3", o_parallel, 8'hC3);
    i_output_enable_n = 1'b1;
    #1;
    check("load_gated", o_parallel, 8'h00);
    i_serial = 1'b1;
    repeat (3) tick();
    i_output_enable_n = 1'b0;
    #1;
    check("hold_keeps_c3", o_parallel, 8'hC3);

    // 5. serial out sequencing with 0x96
    shr_word(8'h96);
    check("shr_96", o_parallel, 8'h96);
    i_mode = SR_SHL;
    #1;
    check("ser_shl_msb", {7'b0, o_serial}, 8'h01);
    i_mode = SR_HOLD;
    #1;
    seq = 8'b1001_0110;
    check("ser_bit0", {7'b0, o_serial}, {7'b0, seq[0]});
    for (int k = 1; k < 8; k++) begin
      i_mode   = SR_SHR;
      i_serial = 1'b0;
      tick();
      check($sformatf("ser_bit%0d", k), {7'b0, o_serial}, {7'b0, seq[k]});
    end
    tick();
    i_mode = SR_HOLD;
    #1;
    check("drain_zero", o_parallel, 8'h00);

    // 6. async reset mid-shift
    for (int i = 0; i < 4; i++) begin
      i_mode   = SR_SHR;
      i_serial = 1'b1;
      tick();
    end
    check("four_ones", o_parallel, 8'hF0);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_par", o_parallel, 8'h00);
    check("async_rst_ser", {7'b0, o_serial}, 8'h00);
    #1;
    i_rst = 1'b0;
    #1;
    check("after_rst_par", o_parallel, 8'h00);
    tick();
    check("resume_shift", o_parallel, 8'h80);
    tick();
    i_mode = SR_HOLD;
    #1;
    check("resume_shift2", o_parallel, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_register
